// File: rtl/yrv_sram_pkg.sv
// Shared types and constants for the YRV 16-bit asynchronous SRAM controller.
// Contents: FSM state enum, mem_trans encodings, halfword select values,
// the captured-transfer payload and a lane-strobe helper.
package yrv_sram_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2
    } state_e;

    // mem_trans encodings; 2'b11 is also a data transfer
    localparam logic [1:0] TRANS_IDLE  = 2'b00;
    localparam logic [1:0] TRANS_FETCH = 2'b01;
    localparam logic [1:0] TRANS_DATA  = 2'b10;

    // Halfword select: LO = bytes 1:0, HI = bytes 3:2
    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    // Address-phase attributes held for the whole data phase
    typedef struct packed {
        logic [3:0] ble;
        logic       write;
    } xfer_t;

    // Active-low {ub_n, lb_n} for the selected halfword
    function automatic logic [1:0] lanes_n(input logic [3:0] ble, input logic half);
        return (half == HALF_HI) ? ~ble[3:2] : ~ble[1:0];
    endfunction

endpackage

// File: rtl/yrv_sram_ctrl.sv
// YRV memory-bus slave driving a 16-bit asynchronous SRAM.
// Each 32-bit transfer becomes one or two halfword accesses (LO then HI),
// each a 1-cycle SETUP followed by a WAIT_CYC+1 cycle STROBE.
// Ports:
//   clk, resetb                 clock, async active-low reset
//   mem_trans/addr/ble/write    address phase (captured while mem_ready=1)
//   mem_wdata                   write data, stable through the data phase
//   mem_ready, mem_rdata        data-phase completion and read data
//   sram_addr                   halfword address
//   sram_dq_out/oe/in           data pad (dq_out is combinational)
//   sram_ce_n/oe_n/we_n/ub_n/lb_n  active-low SRAM strobes
module yrv_sram_ctrl
    import yrv_sram_pkg::*;
#(
    parameter int unsigned WAIT_CYC = 1,
    parameter int unsigned AW       = 18
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic [1:0]    mem_trans,
    input  logic [31:0]   mem_addr,
    input  logic [3:0]    mem_ble,
    input  logic          mem_write,
    input  logic [31:0]   mem_wdata,
    output logic          mem_ready,
    output logic [31:0]   mem_rdata,
    output logic [AW-1:0] sram_addr,
    output logic [15:0]   sram_dq_out,
    output logic          sram_dq_oe,
    input  logic [15:0]   sram_dq_in,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic          sram_ub_n,
    output logic          sram_lb_n
);

    localparam int unsigned CW = (WAIT_CYC == 0) ? 1 : $clog2(WAIT_CYC + 1);

    state_e        state_q, state_d;
    logic          half_q, half_d;
    logic [CW-1:0] cnt_q, cnt_d;
    xfer_t         xfer_q, xfer_d;
    logic [AW-2:0] waddr_q, waddr_d;

    logic          ready_q, ready_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          ce_n_q, ce_n_d;
    logic          oe_n_q, oe_n_d;
    logic          we_n_q, we_n_d;
    logic          ub_n_q, ub_n_d;
    logic          lb_n_q, lb_n_d;
    logic          dq_oe_q, dq_oe_d;

    // Byte-offset and aliased upper address bits are intentionally ignored
    logic unused_c;
    assign unused_c = ^{mem_addr[31:AW+1], mem_addr[1:0]};

    // State and registered outputs
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= IDLE;
            half_q  <= HALF_LO;
            cnt_q   <= '0;
            xfer_q  <= '0;
            waddr_q <= '0;
            ready_q <= 1'b1;
            rdata_q <= '0;
            addr_q  <= '0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            cnt_q   <= cnt_d;
            xfer_q  <= xfer_d;
            waddr_q <= waddr_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            ub_n_q  <= ub_n_d;
            lb_n_q  <= lb_n_d;
            dq_oe_q <= dq_oe_d;
        end
    end

    // Next state, read-data capture, and outputs for the coming cycle
    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        cnt_d   = cnt_q;
        xfer_d  = xfer_q;
        waddr_d = waddr_q;
        rdata_d = rdata_q;
        ready_d = 1'b1;
        addr_d  = addr_q;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        dq_oe_d = 1'b0;

        case (state_q)
            IDLE: begin
                // mem_ready is high throughout IDLE, so any non-idle request is captured
                if (mem_trans != TRANS_IDLE) begin
                    xfer_d.ble   = mem_ble;
                    xfer_d.write = mem_write;
                    waddr_d      = mem_addr[AW:2];
                    if (mem_ble != 4'b0000) begin
                        state_d = SETUP;
                        half_d  = (mem_ble[1:0] != 2'b00) ? HALF_LO : HALF_HI;
                    end
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = CW'(WAIT_CYC);
            end
            STROBE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    if (!xfer_q.write) begin
                        if (half_q == HALF_LO) begin
                            if (xfer_q.ble[0]) rdata_d[7:0]  = sram_dq_in[7:0];
                            if (xfer_q.ble[1]) rdata_d[15:8] = sram_dq_in[15:8];
                        end else begin
                            if (xfer_q.ble[2]) rdata_d[23:16] = sram_dq_in[7:0];
                            if (xfer_q.ble[3]) rdata_d[31:24] = sram_dq_in[15:8];
                        end
                    end
                    if ((half_q == HALF_LO) && (xfer_q.ble[3:2] != 2'b00)) begin
                        state_d = SETUP;
                        half_d  = HALF_HI;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Address and lanes change only on SETUP entry; held through STROBE
        if (state_d != IDLE) begin
            ready_d            = 1'b0;
            ce_n_d             = 1'b0;
            addr_d             = {waddr_d, half_d};
            {ub_n_d, lb_n_d}   = lanes_n(xfer_d.ble, half_d);
            dq_oe_d            = xfer_d.write;
            if (state_d == STROBE) begin
                oe_n_d = xfer_d.write;
                we_n_d = ~xfer_d.write;
            end
        end
    end

    assign mem_ready   = ready_q;
    assign mem_rdata   = rdata_q;
    assign sram_addr   = addr_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_ub_n   = ub_n_q;
    assign sram_lb_n   = lb_n_q;
    assign sram_dq_oe  = dq_oe_q;

    // Write data follows the half being accessed
    assign sram_dq_out = (half_q == HALF_HI) ? mem_wdata[31:16] : mem_wdata[15:0];

endmodule
